full_subtractor: RTL and testbench
==================================

// Module: full_subtractor
//
// PURPOSE
//   Registered full subtractor: computes D = X - Y - Z, with borrow-out B.
//   X is the minuend, Y the subtrahend and Z the 1-bit borrow-in.
//   WIDTH=1 is the classic 1-bit full subtractor cell.
//   Used as a leaf arithmetic block, and chainable through Z/B to build wider subtractors.
//   Datapath is a ripple chain of 1-bit cells feeding one output register stage.
//
// PARAMETERS
//   WIDTH   1   bit width of X, Y and D; must be >= 1
//
// PORTS
//   clk        input   1        rising-edge clock
//   rst_n      input   1        asynchronous active-low reset
//   in_valid   input   1        X/Y/Z are valid and are captured on this clk edge
//   X          input   WIDTH    minuend
//   Y          input   WIDTH    subtrahend
//   Z          input   1        borrow-in
//   D          output  WIDTH    difference, registered
//   B          output  1        borrow-out, registered
//   out_valid  output  1        D/B hold a result captured on the previous edge
//
// BEHAVIOUR
//   - Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//   - Reset: while rst_n=0, D=0, B=0 and out_valid=0, immediately and independent of clk.
//     The first capture is on the first rising clk edge after rst_n is released.
//   - Per-bit cell i, with b[0]=Z:
//       d[i]   = X[i] ^ Y[i] ^ b[i]
//       b[i+1] = (~X[i] & Y[i]) | (~(X[i] ^ Y[i]) & b[i])
//     Result: D_next = d[WIDTH-1:0]; B_next = b[WIDTH].
//   - Arithmetic equivalent: {B_next, D_next} = {1'b0, X} - {1'b0, Y} - Z, in (WIDTH+1)-bit
//     two's complement. B_next=1 exactly when X < Y + Z, with operands treated as unsigned.
//   - Latency: 1 cycle. On a rising edge with in_valid=1: D<=D_next, B<=B_next, out_valid<=1.
//   - On a rising edge with in_valid=0: D and B hold their values; out_valid<=0.
//   - Throughput: one operation per cycle; back-to-back in_valid is supported.
//   - Wrap-around: X=0, Y=all-ones, Z=1 gives D=0 and B=1.
//     X=all-ones, Y=0, Z=0 gives D=all-ones and B=0.
//   - Asserting rst_n=0 mid-stream discards any pending result; outputs go to their reset values.
//   - No combinational path from inputs to outputs; all outputs come from flops.
//   - Inputs are X/Z-free whenever in_valid=1; no internal X-propagation handling is required.
//
// TESTING
//   1. Reset: rst_n=0 asynchronously, clk idle -> D=0, B=0, out_valid=0 at once.
//   2. WIDTH=1, exhaustive walk of (X,Y,Z) from 000 to 111, one per cycle with in_valid=1.
//      Required (D,B) one cycle later: 000->(0,0), 001->(1,1), 010->(1,1), 011->(0,1),
//      100->(1,0), 101->(0,0), 110->(0,0), 111->(1,1).
//   3. WIDTH=8: X=8'h05, Y=8'h03, Z=0 -> D=8'h02, B=0.
//      WIDTH=8: X=8'h00, Y=8'hFF, Z=1 -> D=8'h00, B=1.
//   4. Hold: capture X=1, Y=0, Z=0 (D=1, B=0), then drop in_valid and change the inputs
//      -> D and B stay (1,0); out_valid=0 from the next edge.
//   5. Mid-stream reset: with in_valid=1 and X=1, Y=1, Z=1, pulse rst_n low between edges
//      -> outputs go to 0 immediately; the first post-release edge yields D=1, B=1.
//   6. Random: 10k random X/Y/Z vectors at WIDTH=1,4,8 -> {B,D} matches {1'b0,X}-{1'b0,Y}-Z
//      one cycle later.

Source files
------------

// File: rtl/full_subtractor.sv
// Registered full subtractor: {B, D} = X - Y - Z through a ripple chain of 1-bit
// borrow cells, captured into a single output register stage when in_valid is high.
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Z,
    output logic [WIDTH-1:0] D,
    output logic             B,
    output logic             out_valid
);

    // One subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic bin);
        logic d;
        logic bout;
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
        return {bout, d};
    endfunction

    logic [WIDTH-1:0] diff_s;
    logic [WIDTH:0]   borrow_s;
    logic [WIDTH-1:0] d_r;
    logic             b_r;
    logic             valid_r;

    // Ripple the borrow from bit 0 (seeded by Z) up to the top cell.
    always_comb begin
        diff_s      = '0;
        borrow_s    = '0;
        borrow_s[0] = Z;
        for (int i = 0; i < WIDTH; i++) begin
            {borrow_s[i+1], diff_s[i]} = sub_cell(X[i], Y[i], borrow_s[i]);
        end
    end

    // Output stage: capture on in_valid, otherwise hold the result and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r     <= '0;
            b_r     <= 1'b0;
            valid_r <= 1'b0;
        end else if (in_valid) begin
            d_r     <= diff_s;
            b_r     <= borrow_s[WIDTH];
            valid_r <= 1'b1;
        end else begin
            d_r     <= d_r;
            b_r     <= b_r;
            valid_r <= 1'b0;
        end
    end

    assign D         = d_r;
    assign B         = b_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor at WIDTH=1, 4 and 8, checked against an unsigned
// arithmetic model of X - Y - Z with one cycle of latency.
module tb_full_subtractor;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic       in_valid;
    logic       x1, y1, z1;
    logic [3:0] x4, y4;
    logic       z4;
    logic [7:0] x8, y8;
    logic       z8;
    logic       d1, b1, ov1;
    logic [3:0] d4;
    logic       b4, ov4;
    logic [7:0] d8;
    logic       b8, ov8;

    int         vectors;
    int         miscompares;
    logic [8:0] e1, e4, e8;
    logic       ev;

    full_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .X(x1), .Y(y1), .Z(z1), .D(d1), .B(b1), .out_valid(ov1)
    );
    full_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .X(x4), .Y(y4), .Z(z4), .D(d4), .B(b4), .out_valid(ov4)
    );
    full_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .X(x8), .Y(y8), .Z(z8), .D(d8), .B(b8), .out_valid(ov8)
    );

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    // Reference: borrow is set when X < Y + Z; difference wraps modulo 2^w.
    function automatic logic [8:0] ref_sub(input int w, input int x, input int y, input int z);
        int m;
        int diff;
        int borrow;
        m      = 1 << w;
        borrow = (x < y + z) ? 1 : 0;
        diff   = x - y - z + borrow * m;
        return 9'((borrow << w) | diff);
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("w1_bd", 9'({b1, d1}), e1);
        chk("w1_ov", 9'(ov1), 9'(ev));
        chk("w4_bd", 9'({b4, d4}), e4);
        chk("w4_ov", 9'(ov4), 9'(ev));
        chk("w8_bd", 9'({b8, d8}), e8);
        chk("w8_ov", 9'(ov8), 9'(ev));
    endtask

    task automatic clear_model();
        e1 = 9'd0;
        e4 = 9'd0;
        e8 = 9'd0;
        ev = 1'b0;
    endtask

    task automatic rand_inputs();
        x1 = 1'($urandom); y1 = 1'($urandom); z1 = 1'($urandom);
        x4 = 4'($urandom); y4 = 4'($urandom); z4 = 1'($urandom);
        x8 = 8'($urandom); y8 = 8'($urandom); z8 = 1'($urandom);
    endtask

    // Let one rising edge happen, advance the model, then compare.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (in_valid) begin
            e1 = ref_sub(1, int'(x1), int'(y1), int'(z1));
            e4 = ref_sub(4, int'(x4), int'(y4), int'(z4));
            e8 = ref_sub(8, int'(x8), int'(y8), int'(z8));
        end
        ev = in_valid;
        check_all();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk_run     = 1'b0;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        rand_inputs();
        clear_model();

        // Reset with the clock idle.
        #2 rst_n = 1'b0;
        #1 check_all();
        #2 rst_n = 1'b1;
        clk_run = 1'b1;

        // Exhaustive 1-bit walk; spot-check the spec table values too.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            rand_inputs();
            in_valid = 1'b1;
            {x1, y1, z1} = 3'(v);
            cycle();
        end
        chk("w1_last_111", 9'({b1, d1}), 9'b0_0000_0011);

        // Directed wide cases and wrap-around corners.
        @(negedge clk);
        rand_inputs();
        x8 = 8'h05; y8 = 8'h03; z8 = 1'b0;
        x4 = 4'h0;  y4 = 4'hF;  z4 = 1'b1;
        cycle();
        chk("w8_5m3", 9'({b8, d8}), 9'h002);
        chk("w4_wrap", 9'({b4, d4}), 9'h010);

        @(negedge clk);
        rand_inputs();
        x8 = 8'h00; y8 = 8'hFF; z8 = 1'b1;
        x4 = 4'hF;  y4 = 4'h0;  z4 = 1'b0;
        cycle();
        chk("w8_wrap", 9'({b8, d8}), 9'h100);
        chk("w4_allones", 9'({b4, d4}), 9'h00F);

        // Hold: capture 1-0-0, then drop in_valid and change inputs.
        @(negedge clk);
        x1 = 1'b1; y1 = 1'b0; z1 = 1'b0;
        x4 = 4'd1; y4 = 4'd0; z4 = 1'b0;
        x8 = 8'd1; y8 = 8'd0; z8 = 1'b0;
        cycle();
        @(negedge clk);
        in_valid = 1'b0;
        rand_inputs();
        cycle();
        chk("hold_w8", 9'({b8, d8}), 9'h001);
        @(negedge clk);
        rand_inputs();
        cycle();

        // Mid-stream reset between edges, then recapture 1-1-1.
        @(negedge clk);
        in_valid = 1'b1;
        x1 = 1'b1; y1 = 1'b1; z1 = 1'b1;
        x4 = 4'd1; y4 = 4'd1; z4 = 1'b1;
        x8 = 8'd1; y8 = 8'd1; z8 = 1'b1;
        #1 rst_n = 1'b0;
        #1 clear_model();
        check_all();
        #1 rst_n = 1'b1;
        cycle();
        chk("rst_w1_111", 9'({b1, d1}), 9'h003);

        // Random traffic with occasional idle cycles.
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            rand_inputs();
            in_valid = ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
